// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants: PC/instruction widths, reset vector,
// next-PC select encodings and the buffered fetch entry.
package mips_pkg;
  localparam int PC_W   = 30;
  localparam int INST_W = 32;

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam pc_t RESET_PC = 30'h0C00;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  // One buffered instruction together with the word address it came from.
  typedef struct packed {
    inst_t inst;
    pc_t   pc;
  } fetch_ent_t;
endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit boundary: redirect input, instruction-memory request/response
// channel and the decode-side instruction handshake.
interface ifu_fetch_if;
  import mips_pkg::*;

  logic  redirect;
  pc_t   npc_in;
  logic  imem_req_valid;
  logic  imem_req_ready;
  pc_t   imem_req_addr;
  logic  imem_rsp_valid;
  inst_t imem_rsp_data;
  logic  inst_valid;
  logic  inst_ready;
  inst_t inst_out;
  pc_t   inst_pc;

  modport master (
    input  redirect, npc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc
  );

  modport slave (
    output redirect, npc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc
  );
endinterface

// File: rtl/fifo_sync.sv
// Small synchronous FIFO with first-word-fall-through head, occupancy count
// and a flush that empties it in one cycle. DEPTH must be a power of two.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited memory
// requests, buffers in-order responses and drops stale ones after a redirect.
module ifu_fetch
  import mips_pkg::*;
#(
  parameter pc_t RESET_PC = mips_pkg::RESET_PC,
  parameter int  DEPTH    = 2
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  pc_t           r_fetch_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] w_tag_count;
  logic [CW-1:0] w_buf_count;
  pc_t           w_tag;
  fetch_ent_t    w_buf_din;
  fetch_ent_t    w_buf_dout;
  logic          w_credit;
  logic          w_req_fire;
  logic          w_rsp_fire;
  logic          w_drop;
  logic          w_buf_push;
  logic          w_buf_pop;
  logic          w_inst_valid;

  // Credit covers both in-flight requests and buffered words, so the buffer cannot overflow.
  assign w_credit   = ({1'b0, r_outstanding} + {1'b0, w_buf_count}) < (CW+1)'(DEPTH);
  assign w_req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign w_rsp_fire = !rst && bus.imem_rsp_valid && (r_outstanding != '0);
  assign w_drop     = (r_drop_cnt != '0);
  assign w_buf_push = w_rsp_fire && !w_drop && !bus.redirect;
  assign w_inst_valid = !rst && (w_buf_count != '0);
  assign w_buf_pop  = w_inst_valid && bus.inst_ready;
  assign w_buf_din  = '{inst: bus.imem_rsp_data, pc: w_tag};

  assign bus.imem_req_valid = !rst && !bus.redirect && w_credit;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = w_inst_valid;
  assign bus.inst_out       = rst ? '0 : w_buf_dout.inst;
  assign bus.inst_pc        = rst ? '0 : w_buf_dout.pc;

  fifo_sync #(.WIDTH(PC_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (1'b0),
    .i_push  (w_req_fire),
    .i_din   (r_fetch_pc),
    .i_pop   (w_rsp_fire),
    .o_dout  (w_tag),
    .o_count (w_tag_count)
  );

  fifo_sync #(.WIDTH($bits(fetch_ent_t)), .DEPTH(DEPTH)) u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.redirect),
    .i_push  (w_buf_push),
    .i_din   (w_buf_din),
    .i_pop   (w_buf_pop),
    .o_dout  (w_buf_dout),
    .o_count (w_buf_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_fire);
      if (bus.redirect) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_fetch_pc <= bus.npc_in;
        r_drop_cnt <= r_outstanding - CW'(w_rsp_fire);
      end else begin
        if (w_req_fire)           r_fetch_pc <= r_fetch_pc + pc_t'(1);
        if (w_rsp_fire && w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_rsp_expected: assert (!(bus.imem_rsp_valid && (r_outstanding == '0)));
      a_tag_tracks:   assert (w_tag_count == r_outstanding);
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: vector table, directed corner sequences
// and a randomized run against a queue-based model of the fetch contract.
module tb_ifu_fetch;
  import mips_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_fetch_if bus();

  ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    pc_t         pc;
    int unsigned epoch;
    int unsigned due;
  } req_t;

  typedef struct {
    logic inst_ready;
    logic exp_req_valid;
    pc_t  exp_req_addr;
    logic exp_inst_valid;
    pc_t  exp_inst_pc;
  } vec_t;

  req_t        mem_q[$];
  pc_t         model_buf[$];
  pc_t         deliv_q[$];
  int unsigned epoch = 0;
  int unsigned cyc = 0;
  int unsigned last_due = 0;
  int          n_req = 0;
  int          max_occ = 0;
  pc_t         exp_req = RESET_PC;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        g_rst = 1'b1;
  logic        g_inst_ready = 1'b1;
  logic        g_req_ready = 1'b1;
  int unsigned g_lat = 1;
  logic        g_verbose = 1'b0;
  logic        s_req_valid, s_inst_valid, s_rsp, s_pop;
  pc_t         s_req_addr, s_inst_pc;
  inst_t       s_inst_out;

  function automatic inst_t mem_word(pc_t pc);
    return {2'b01, pc} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later, update the model.
  task automatic step(input logic rdr, input pc_t npc);
    int   occ;
    req_t r;
    @(negedge clk);
    rst                = g_rst;
    bus.redirect       = rdr && !g_rst;
    bus.npc_in         = npc;
    bus.inst_ready     = g_inst_ready;
    bus.imem_req_ready = g_req_ready;
    s_rsp = 1'b0;
    if (!g_rst && mem_q.size() > 0) s_rsp = (mem_q[0].due <= cyc);
    bus.imem_rsp_valid = s_rsp;
    bus.imem_rsp_data  = s_rsp ? mem_word(mem_q[0].pc) : inst_t'($urandom);
    #1;
    s_req_valid  = bus.imem_req_valid;
    s_req_addr   = bus.imem_req_addr;
    s_inst_valid = bus.inst_valid;
    s_inst_pc    = bus.inst_pc;
    s_inst_out   = bus.inst_out;
    s_pop        = 1'b0;
    if (g_rst) begin
      chk("rst_req_valid", s_req_valid, 0);
      chk("rst_inst_valid", s_inst_valid, 0);
      chk("rst_inst_out", s_inst_out, 0);
      chk("rst_inst_pc", s_inst_pc, 0);
      mem_q.delete();
      model_buf.delete();
      epoch++;
      exp_req  = RESET_PC;
      last_due = cyc;
      n_req    = 0;
    end else begin
      occ = mem_q.size() + model_buf.size();
      if (occ > max_occ) max_occ = occ;
      chk("req_valid", s_req_valid, (!rdr && occ < DEPTH) ? 1 : 0);
      if (s_req_valid) chk("req_addr", s_req_addr, exp_req);
      chk("inst_valid", s_inst_valid, (model_buf.size() != 0) ? 1 : 0);
      if (s_inst_valid && model_buf.size() != 0) begin
        chk("inst_pc", s_inst_pc, model_buf[0]);
        chk("inst_out", s_inst_out, mem_word(model_buf[0]));
      end
      s_pop = s_inst_valid && g_inst_ready;
      if (s_pop) begin
        deliv_q.push_back(s_inst_pc);
        if (g_verbose) $display("cycle %0d: deliver pc=%08h inst=%08h", cyc, s_inst_pc, s_inst_out);
        if (model_buf.size() != 0) void'(model_buf.pop_front());
      end
      if (rdr) begin
        model_buf.delete();
        epoch++;
        exp_req = npc;
      end
      if (s_rsp) begin
        r = mem_q.pop_front();
        if (r.epoch == epoch) model_buf.push_back(r.pc);
      end
      if (s_req_valid && g_req_ready) begin
        r.pc    = s_req_addr;
        r.epoch = epoch;
        r.due   = (cyc + g_lat > last_due + 1) ? cyc + g_lat : last_due + 1;
        last_due = r.due;
        mem_q.push_back(r);
        exp_req = exp_req + pc_t'(1);
        n_req++;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    g_rst = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    g_rst = 1'b0;
    deliv_q.delete();
    max_occ = 0;
  endtask

  task automatic run_until_deliv(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (deliv_q.size() < n && k < budget) begin
      step(1'b0, '0);
      k++;
    end
    chk({name, "_count"}, deliv_q.size(), n);
  endtask

  vec_t vecs[10];
  pc_t  hold_pc;
  logic have_hold;

  initial begin
    bus.redirect = 1'b0;
    bus.npc_in = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.inst_ready = 1'b0;

    // Reset release, 1-cycle memory, decode always ready: credit-limited cadence.
    vecs[0] = '{1'b1, 1'b1, 30'h0C00, 1'b0, 30'h0};
    vecs[1] = '{1'b1, 1'b1, 30'h0C01, 1'b0, 30'h0};
    vecs[2] = '{1'b1, 1'b0, 30'h0,    1'b1, 30'h0C00};
    vecs[3] = '{1'b1, 1'b1, 30'h0C02, 1'b1, 30'h0C01};
    vecs[4] = '{1'b1, 1'b1, 30'h0C03, 1'b0, 30'h0};
    vecs[5] = '{1'b1, 1'b0, 30'h0,    1'b1, 30'h0C02};
    vecs[6] = '{1'b1, 1'b1, 30'h0C04, 1'b1, 30'h0C03};
    vecs[7] = '{1'b1, 1'b1, 30'h0C05, 1'b0, 30'h0};
    vecs[8] = '{1'b1, 1'b0, 30'h0,    1'b1, 30'h0C04};
    vecs[9] = '{1'b1, 1'b1, 30'h0C06, 1'b1, 30'h0C05};

    g_lat = 1; g_req_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      g_inst_ready = vecs[i].inst_ready;
      step(1'b0, '0);
      $display("vector %0d: req_valid=%0b addr=%08h inst_valid=%0b pc=%08h",
               i, s_req_valid, s_req_addr, s_inst_valid, s_inst_pc);
      chk("vec_req_valid", s_req_valid, vecs[i].exp_req_valid);
      if (vecs[i].exp_req_valid) chk("vec_req_addr", s_req_addr, vecs[i].exp_req_addr);
      chk("vec_inst_valid", s_inst_valid, vecs[i].exp_inst_valid);
      if (vecs[i].exp_inst_valid) chk("vec_inst_pc", s_inst_pc, vecs[i].exp_inst_pc);
    end

    g_verbose = 1'b1;

    // Decode stall: only DEPTH requests may be accepted, head stays stable.
    do_reset();
    g_inst_ready = 1'b0;
    have_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0);
      if (s_inst_valid && have_hold) chk("stall_pc_stable", s_inst_pc, hold_pc);
      if (s_inst_valid && !have_hold) begin hold_pc = s_inst_pc; have_hold = 1'b1; end
    end
    chk("stall_reqs", n_req, DEPTH);
    chk("stall_head_seen", have_hold, 1);
    g_inst_ready = 1'b1;
    run_until_deliv(2, 20, "stall_release");
    if (deliv_q.size() >= 2) begin
      chk("stall_first", deliv_q[0], 30'h0C00);
      chk("stall_second", deliv_q[1], 30'h0C01);
    end

    // Toggling request ready with 3-cycle memory latency.
    g_lat = 3;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      g_req_ready = (i % 2 == 0);
      step(1'b0, '0);
    end
    g_req_ready = 1'b1;
    chk("toggle_occ_bound", (max_occ <= DEPTH) ? 1 : 0, 1);
    chk("toggle_progress", (deliv_q.size() >= 5) ? 1 : 0, 1);
    for (int k = 0; k < deliv_q.size(); k++) chk("toggle_seq", deliv_q[k], 30'h0C00 + k);

    // Redirect with two requests outstanding.
    g_lat = 4;
    do_reset();
    step(1'b0, '0);
    step(1'b0, '0);
    chk("rd_inflight", mem_q.size(), 2);
    step(1'b1, 30'h0D40);
    deliv_q.delete();
    run_until_deliv(2, 30, "rd_deliv");
    if (deliv_q.size() >= 2) begin
      chk("rd_first", deliv_q[0], 30'h0D40);
      chk("rd_second", deliv_q[1], 30'h0D41);
    end

    // Redirect coinciding with a response and a pop, then a second redirect.
    g_lat = 1;
    do_reset();
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b1, 30'h2000);
    chk("dbl_rsp_in_r", s_rsp, 1);
    chk("dbl_pop_in_r", s_pop, 1);
    step(1'b1, 30'h0100);
    deliv_q.delete();
    run_until_deliv(4, 40, "dbl_deliv");
    for (int k = 0; k < deliv_q.size(); k++) chk("dbl_seq", deliv_q[k], 30'h0100 + k);

    // Fetch PC wrap at the top of the address space.
    g_lat = 2;
    do_reset();
    step(1'b1, 30'h3FFF_FFFF);
    run_until_deliv(2, 30, "wrap_deliv");
    if (deliv_q.size() >= 2) begin
      chk("wrap_first", deliv_q[0], 30'h3FFF_FFFF);
      chk("wrap_second", deliv_q[1], 30'h0);
    end

    // Reset while responses are in flight.
    g_lat = 5;
    step(1'b0, '0);
    step(1'b0, '0);
    chk("rst_pre_inflight", (mem_q.size() != 0) ? 1 : 0, 1);
    g_rst = 1'b1;
    step(1'b0, '0);
    g_rst = 1'b0;
    deliv_q.delete();
    run_until_deliv(1, 30, "rst_refetch");
    if (deliv_q.size() >= 1) chk("rst_refetch_pc", deliv_q[0], 30'h0C00);

    // Randomized traffic against the model.
    g_verbose = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic rdr;
      g_req_ready  = ($urandom_range(0, 3) != 0);
      g_inst_ready = ($urandom_range(0, 3) != 0);
      g_lat        = $urandom_range(1, 4);
      g_rst        = ($urandom_range(0, 199) == 0);
      rdr          = ($urandom_range(0, 19) == 0);
      step(rdr, pc_t'($urandom));
    end
    g_rst = 1'b0;
    chk("rand_occ_bound", (max_occ <= DEPTH) ? 1 : 0, 1);
    chk("rand_progress", (deliv_q.size() > 200) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
